// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between decode controls and a word-wide req/ack bus
//
// Purpose: aligns store data and byte enables to the bus lanes, splits a misaligned access
// that crosses a word boundary into two aligned transfers, extends load data, and stalls the
// core until the access completes.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   start                           access request, sampled only in IDLE
//   memrw, memword, memsign         0 load / 1 store; size 00 byte 01 half 10 word 11 illegal;
//                                   load extension 0 sign / 1 zero
//   addr, wdata                     byte address, right-justified store data
//   stall                           core must hold this cycle
//   done, fault, rdata              completion pulse, fault qualifier, extended load data
//   bus_req, bus_we, bus_addr,      registered bus request and word-aligned transfer attributes
//   bus_be, bus_wdata
//   bus_ack, bus_rdata              transfer completion and read data from the bus
module lsu_ctrl #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        memrw,
    input  logic [1:0]  memword,
    input  logic        memsign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state_q, state_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    // second-transfer lanes, precomputed at request time so ACC1 only has to load them
    logic [3:0]  be_hi_q, be_hi_d;
    logic [31:0] wd_hi_q, wd_hi_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        zext_q, zext_d;
    logic        rw_q, rw_d;
    logic        cross_q, cross_d;
    logic [31:0] lo_q, lo_d;

    logic [2:0]  n_bytes;
    logic [3:0]  mask4;
    logic        cross_in;
    logic        illegal;
    logic [7:0]  be8;
    logic [63:0] wd64;

    function automatic logic [31:0] extend(input logic [63:0] raw_in, input logic [1:0] off,
                                           input logic [1:0] size, input logic zext);
        logic [31:0] raw;
        raw = 32'(raw_in >> {off, 3'b000});
        case (size)
            2'b00:   extend = {{24{raw[7] & ~zext}}, raw[7:0]};
            2'b01:   extend = {{16{raw[15] & ~zext}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    always_comb begin
        case (memword)
            2'b00:   begin n_bytes = 3'd1; mask4 = 4'b0001; end
            2'b01:   begin n_bytes = 3'd2; mask4 = 4'b0011; end
            default: begin n_bytes = 3'd4; mask4 = 4'b1111; end
        endcase
        illegal  = (memword == 2'b11);
        cross_in = ({2'b00, addr[1:0]} + {1'b0, n_bytes}) > 4'd4;
        be8      = {4'b0000, mask4} << addr[1:0];
        wd64     = {32'd0, wdata} << {addr[1:0], 3'b000};
    end

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        rdata_d     = rdata_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        be_hi_d     = be_hi_q;
        wd_hi_d     = wd_hi_q;
        off_d       = off_q;
        size_d      = size_q;
        zext_d      = zext_q;
        rw_d        = rw_q;
        cross_d     = cross_q;
        lo_d        = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (illegal || (cross_in && !SPLIT_EN)) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d     = ACC0;
                        fault_d     = 1'b0;
                        off_d       = addr[1:0];
                        size_d      = memword;
                        zext_d      = memsign;
                        rw_d        = memrw;
                        cross_d     = cross_in;
                        bus_req_d   = 1'b1;
                        bus_we_d    = memrw;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be8[3:0];
                        bus_wdata_d = wd64[31:0];
                        be_hi_d     = be8[7:4];
                        wd_hi_d     = wd64[63:32];
                    end
                end
            end
            ACC0: begin
                if (bus_ack) begin
                    lo_d = bus_rdata;
                    if (cross_q) begin
                        // bus_req stays high; only the transfer attributes advance
                        state_d     = ACC1;
                        bus_addr_d  = bus_addr_q + 32'd4;
                        bus_be_d    = be_hi_q;
                        bus_wdata_d = wd_hi_q;
                    end else begin
                        state_d   = DONE;
                        bus_req_d = 1'b0;
                        if (!rw_q) rdata_d = extend({32'd0, bus_rdata}, off_q, size_q, zext_q);
                    end
                end
            end
            ACC1: begin
                if (bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!rw_q) rdata_d = extend({bus_rdata, lo_q}, off_q, size_q, zext_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fault_q     <= 1'b0;
            rdata_q     <= 32'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            be_hi_q     <= 4'd0;
            wd_hi_q     <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            zext_q      <= 1'b0;
            rw_q        <= 1'b0;
            cross_q     <= 1'b0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            be_hi_q     <= be_hi_d;
            wd_hi_q     <= wd_hi_d;
            off_q       <= off_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
            rw_q        <= rw_d;
            cross_q     <= cross_d;
            lo_q        <= lo_d;
        end
    end

    assign done      = (state_q == DONE);
    assign fault     = (state_q == DONE) && fault_q;
    assign stall     = ((state_q == IDLE) && start) || (state_q == ACC0) || (state_q == ACC1);
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
